// File: rtl/vector_activation.sv
// Serial per-lane FP16 activation stage (pass / ReLU / leaky ReLU / ReLU6) behind vector_adder.
// One lane is written per cycle; ready pulses once the whole vector is in Out.
module vector_activation #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic [NUM_UNITS-1:0]            active_units,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] In,
    output logic [NUM_UNITS*DATA_WIDTH-1:0] Out,
    output logic                            ready,
    output logic                            busy
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [4:0] LEAK_E = 5'(LEAK_SHIFT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROCESS = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ready_q, ready_d;
    logic   busy_q, busy_d;

    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] in_q;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] out_q;
    logic [1:0]                           mode_q;
    logic [NUM_UNITS-1:0]                 mask_q;
    logic [IDX_W-1:0]                     idx_q;

    // Bit-level activation; the only arithmetic is the 5-bit exponent decrement for leaky ReLU.
    function automatic logic [DATA_WIDTH-1:0] act(input logic [1:0] md, input logic [DATA_WIDTH-1:0] x);
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        logic       is_nan;
        s      = x[15];
        e      = x[14:10];
        m      = x[9:0];
        is_nan = (e == 5'd31) && (m != 10'd0);
        act    = x;
        if (md != 2'b00 && is_nan) begin
            act = 16'h7E00;
        end else begin
            case (md)
                2'b01: if (s) act = 16'h0000;
                2'b10: begin
                    if (s && e != 5'd31) begin
                        if (e <= LEAK_E) act = 16'h8000;
                        else             act = {1'b1, e - LEAK_E, m};
                    end
                end
                2'b11: begin
                    if (s)                        act = 16'h0000;
                    else if (x[14:0] > 15'h4600)  act = 16'h4600;
                end
                default: act = x;
            endcase
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PROCESS;
            PROCESS: if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered one cycle behind the state so busy stays high through the ready cycle.
    always_comb begin
        ready_d = (state_q == DONE);
        busy_d  = (state_q != IDLE) || start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q   <= '0;
            out_q  <= '0;
            mode_q <= 2'b00;
            mask_q <= '0;
            idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        in_q   <= In;
                        mode_q <= mode;
                        mask_q <= active_units;
                        out_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                PROCESS: begin
                    out_q[idx_q] <= mask_q[idx_q] ? act(mode_q, in_q[idx_q]) : '0;
                    idx_q        <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign Out   = out_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_vector_activation.sv
// Randomized bench for vector_activation against an FP16 activation reference model.
// Checks reset, lane timing, handshake robustness, mid-run reset and back-to-back operation.
module tb_vector_activation;

    localparam int NU = 4;
    localparam int LS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [NU-1:0] active_units;
    logic [63:0]   In;
    logic [63:0]   Out;
    logic          ready;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_activation #(.DATA_WIDTH(16), .NUM_UNITS(NU), .LEAK_SHIFT(LS)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .active_units(active_units), .In(In), .Out(Out), .ready(ready), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decode the FP16 fields and apply the activation rules numerically.
    function automatic logic [15:0] ref_act(input logic [1:0] md, input logic [15:0] x);
        bit neg;
        int e;
        int m;
        neg = x[15];
        e   = int'(x[14:10]);
        m   = int'(x[9:0]);
        if (md == 2'd0) return x;
        if (e == 31 && m != 0) return 16'h7E00;
        if (md == 2'd1) return neg ? 16'h0000 : x;
        if (md == 2'd2) begin
            if (!neg || e == 31) return x;
            if (e <= LS) return 16'h8000;
            return {1'b1, 5'(e - LS), 10'(m)};
        end
        if (neg) return 16'h0000;
        // 6.0 is 1.5 * 2^2: biased exponent 17, mantissa 512
        if (e > 17 || (e == 17 && m > 512)) return 16'h4600;
        return x;
    endfunction

    function automatic logic [63:0] ref_vec(input logic [1:0] md, input logic [NU-1:0] mask, input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NU; i++)
            r[i*16 +: 16] = mask[i] ? ref_act(md, v[i*16 +: 16]) : 16'h0000;
        return r;
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom_range(0, 7))
            0: x = {x[15], 5'd31, (x[9:0] == 10'd0) ? 10'd1 : x[9:0]};
            1: x = {x[15], 5'd31, 10'd0};
            2: x = {x[15], 15'd0};
            3: x = {x[15], 5'($urandom_range(0, 4)), x[9:0]};
            4: x = {x[15], 5'd17, x[9:0]};
            default: ;
        endcase
        return x;
    endfunction

    // One full request: T0 is the edge that samples start; outputs checked 1ns after each edge.
    task automatic run_vector(input logic [1:0] md, input logic [NU-1:0] mask, input logic [63:0] v,
                              input bit poke, output logic [63:0] got);
        logic [63:0] exp;
        exp = ref_vec(md, mask, v);
        @(negedge clk);
        start = 1'b1; mode = md; active_units = mask; In = v;
        @(posedge clk); #1;
        check_eq("busy_at_t0", 64'(busy), 64'd1);
        check_eq("out_cleared", Out, 64'd0);
        start = 1'b0;
        mode = 2'($urandom_range(0, 3));
        active_units = NU'($urandom);
        In = {$urandom(), $urandom()};
        for (int i = 0; i < NU; i++) begin
            @(posedge clk); #1;
            check_eq("lane_update", 64'(Out[i*16 +: 16]), 64'(exp[i*16 +: 16]));
            check_eq("ready_early", 64'(ready), 64'd0);
            if (poke && i == 1) start = 1'b1;
            if (poke && i == 2) start = 1'b0;
        end
        @(posedge clk); #1;
        check_eq("ready_pulse", 64'(ready), 64'd1);
        check_eq("busy_at_ready", 64'(busy), 64'd1);
        check_eq("out_vector", Out, exp);
        @(posedge clk); #1;
        check_eq("ready_width", 64'(ready), 64'd0);
        check_eq("busy_fall", 64'(busy), 64'd0);
        got = Out;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        logic [63:0] v;
        int rdy_cnt;
        int rdy_at[$];

        reset = 1'b1; start = 1'b1; mode = 2'd0; active_units = '0; In = '0;
        #1;
        check_eq("reset_out", Out, 64'd0);
        check_eq("reset_ready", 64'(ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_out_hold", Out, 64'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;

        run_vector(2'd1, 4'b1111, {16'h3C00, 16'hBC00, 16'h0000, 16'h4200}, 1'b0, got);
        check_eq("dir_relu", got, {16'h3C00, 16'h0000, 16'h0000, 16'h4200});
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_hold", Out, {16'h3C00, 16'h0000, 16'h0000, 16'h4200});

        run_vector(2'd0, 4'b1001, {16'h4200, 16'h4200, 16'h0000, 16'h4000}, 1'b0, got);
        check_eq("dir_mask", got, {16'h4200, 16'h0000, 16'h0000, 16'h4000});
        run_vector(2'd2, 4'b1111, {16'hC000, 16'h8400, 16'hFC00, 16'h7E01}, 1'b1, got);
        check_eq("dir_leaky", got, {16'hB400, 16'h8000, 16'hFC00, 16'h7E00});
        run_vector(2'd3, 4'b1111, {16'h4700, 16'h7C00, 16'h4600, 16'hC500}, 1'b1, got);
        check_eq("dir_relu6", got, {16'h4600, 16'h4600, 16'h4600, 16'h0000});
        run_vector(2'd0, 4'b0000, {16'h7E01, 16'h3C00, 16'hFFFF, 16'h1234}, 1'b0, got);
        check_eq("dir_mask0", got, 64'd0);

        // Reset while lane 2 is about to be written
        @(negedge clk);
        start = 1'b1; mode = 2'd0; active_units = 4'b1111; In = {$urandom(), $urandom()};
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("abort_out", Out, 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ready) rdy_cnt++;
        end
        check_eq("abort_no_ready", 64'(rdy_cnt), 64'd0);
        check_eq("abort_idle_busy", 64'(busy), 64'd0);
        v = {16'hC000, 16'h3C00, 16'h7C00, 16'h8001};
        run_vector(2'd1, 4'b1111, v, 1'b0, got);
        check_eq("after_abort", got, {16'h0000, 16'h3C00, 16'h7C00, 16'h0000});

        // start held high across two requests
        v = {rand_fp16(), rand_fp16(), rand_fp16(), rand_fp16()};
        @(negedge clk);
        start = 1'b1; mode = 2'd2; active_units = 4'b1011; In = v;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (k == NU + 2) start = 1'b0;
            if (ready) rdy_at.push_back(k);
        end
        check_eq("b2b_count", 64'(rdy_at.size()), 64'd2);
        if (rdy_at.size() == 2) begin
            check_eq("b2b_first", 64'(rdy_at[0]), 64'(NU + 1));
            check_eq("b2b_gap", 64'(rdy_at[1] - rdy_at[0]), 64'(NU + 2));
        end
        check_eq("b2b_out", Out, ref_vec(2'd2, 4'b1011, v));

        for (int t = 0; t < 40; t++) begin
            v = {rand_fp16(), rand_fp16(), rand_fp16(), rand_fp16()};
            run_vector(2'($urandom_range(0, 3)), NU'($urandom), v, 1'($urandom), got);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_activation.md
# vector_activation

Downstream stage of `vector_adder`: consumes its biased FP16 (IEEE 754 half) result vector and applies a per-lane activation function (pass, ReLU, leaky ReLU, ReLU6). Lanes are processed serially, one per cycle, under the same `active_units` mask and `start`/`ready` handshake as the adder. The registered output vector feeds the TTPU result writeback.

## Interface
- `DATA_WIDTH`, 16: element width. Only 16 (FP16) is supported.
- `NUM_UNITS`, 4: number of lanes. Must be ≥ 1.
- `LEAK_SHIFT`, 3: leaky-ReLU negative slope is 2^-LEAK_SHIFT. Range 1..14.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  2  00 pass, 01 ReLU, 10 leaky ReLU, 11 ReLU6. Latched at start.
- `active_units`  in  NUM_UNITS  lane enable mask. Latched at start.
- `In`  in  NUM_UNITS×DATA_WIDTH  input vector, normally `vector_adder.Out`. Latched at start.
- `Out`  out  NUM_UNITS×DATA_WIDTH  registered result vector.
- `ready`  out  1  one-cycle pulse: `Out` is complete.
- `busy`  out  1  high from start acceptance until `ready` has pulsed.

## Operation
- FSM states: IDLE, PROCESS, DONE.
- IDLE: `busy`=0. On `start`=1, latch `In`, `mode`, `active_units`; clear `Out` to all zeros; lane index := 0; go to PROCESS.
- PROCESS: each cycle, write `Out[idx]` = f(latched `In[idx]`) if `active_units[idx]`=1, else 16'h0000. Then idx += 1. After lane NUM_UNITS-1 go to DONE.
- DONE: `ready`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE. Input changes after the start cycle have no effect.
- `Out` holds its value in IDLE until the next accepted start.
- f() on x = {s, e[4:0], m[9:0]}:
  - NaN (e=31, m≠0): pass mode returns x unchanged. All other modes return canonical 16'h7E00.
  - pass: x.
  - ReLU: s=1 → 16'h0000, including -0 and -inf. Otherwise x.
  - leaky: s=0 → x. s=1 and e=31 (-inf) → x. s=1 and e ≤ LEAK_SHIFT → 16'h8000 (flush to -0, no subnormal output). Otherwise {1, e-LEAK_SHIFT, m}.
  - ReLU6: s=1 → 16'h0000. s=0 and x > 16'h4600 (6.0, including +inf) → 16'h4600. Otherwise x.
- Operation is purely bit-level: no rounding and no adders wider than 5 bits.

## Timing
- Reset values: `Out`=0, `ready`=0, `busy`=0, state IDLE, idx=0. Reset asserted mid-operation aborts immediately; no `ready` is produced for the aborted request.
- `start` sampled high at edge T0:
  - `busy`=1 from T0.
  - `Out[i]` updates at edge T0+1+i.
  - `ready`=1 from edge T0+NUM_UNITS+1 for one cycle.
  - `busy` falls at edge T0+NUM_UNITS+2, together with `ready`.
- Start-to-ready latency: NUM_UNITS+1 cycles.
- Earliest next accepted start: the cycle after `ready` (back-to-back throughput: one vector per NUM_UNITS+2 cycles).
- `start` held high continuously: a new request is accepted on each return to IDLE.
- `active_units`=0: all lanes write 0. Timing and `ready` are unchanged.

## Test plan
- Reset: `Out`, `ready`, `busy` = 0 during and after reset. Then ReLU, mask 4'b1111, In={3C00, BC00, 0000, 4200} → Out={3C00, 0000, 0000, 4200}; `ready` 5 cycles after start, 1 cycle wide.
- Mask with adder-like values: pass mode, mask 4'b1001, In={4200, 4200, 0000, 4000} → Out={4200, 0000, 0000, 4000}.
- Leaky, LEAK_SHIFT=3: In={C000, 8400, FC00, 7E01} → Out={B400, 8000, FC00, 7E00}.
- ReLU6: In={4700, 7C00, 4600, C500} → Out={4600, 4600, 4600, 0000}.
- Handshake robustness: `start` pulsed while busy → ignored, exactly one `ready`. Inputs changed mid-run → latched results unchanged. Reset at lane 2 → outputs zero, no `ready`; a new start afterwards completes normally.
- Back-to-back: `start` held high across two requests → two `ready` pulses 6 cycles apart (NUM_UNITS=4).
